// File: rtl/qbert_mtl_pkg.sv
// Shared timing defaults, pixel type and colour-bar table for the MTL 800x480 pixel path.
package qbert_mtl_pkg;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 210;
  localparam int unsigned H_SYNC   = 30;
  localparam int unsigned H_BP     = 16;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 22;
  localparam int unsigned V_SYNC   = 13;
  localparam int unsigned V_BP     = 10;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned PIPE_LAT = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned BAR_WIDTH = 100;

  // Entry 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/mtl_pixel_timing_gen_if.sv
// Pixel bus between the timing generator, the colour renderer, the MTL panel and the NIOS side.
interface mtl_pixel_timing_gen_if;

  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic [7:0]  red_in;
  logic [7:0]  green_in;
  logic [7:0]  blue_in;
  logic [7:0]  lcd_r;
  logic [7:0]  lcd_g;
  logic [7:0]  lcd_b;
  logic        lcd_hsd;
  logic        lcd_vsd;
  logic        lcd_de;
  logic        frame_start;
  logic        vblank;
  logic        upd_req;
  logic        upd_ack;

  modport master (
    output x_cnt, y_cnt, lcd_r, lcd_g, lcd_b, lcd_hsd, lcd_vsd, lcd_de,
    output frame_start, vblank, upd_ack,
    input  red_in, green_in, blue_in, upd_req
  );

  modport slave (
    input  x_cnt, y_cnt, lcd_r, lcd_g, lcd_b, lcd_hsd, lcd_vsd, lcd_de,
    input  frame_start, vblank, upd_ack,
    output red_in, green_in, blue_in, upd_req
  );

endinterface

// File: rtl/mtl_delay_line.sv
// Fixed-depth shift register with asynchronous clear; used to align sync/DE with the renderer.
module mtl_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             CLK_33,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/mtl_pixel_timing_gen.sv
// MTL raster generator: scan counters, pipeline-aligned panel pins and vblank update handshake.
// MTL_TEST_PATTERN_EN adds a test_mode input that swaps renderer colour for 8 vertical bars.
module mtl_pixel_timing_gen #(
  parameter int unsigned H_ACTIVE = qbert_mtl_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = qbert_mtl_pkg::H_FP,
  parameter int unsigned H_SYNC   = qbert_mtl_pkg::H_SYNC,
  parameter int unsigned H_BP     = qbert_mtl_pkg::H_BP,
  parameter int unsigned V_ACTIVE = qbert_mtl_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = qbert_mtl_pkg::V_FP,
  parameter int unsigned V_SYNC   = qbert_mtl_pkg::V_SYNC,
  parameter int unsigned V_BP     = qbert_mtl_pkg::V_BP,
  parameter int unsigned PIPE_LAT = qbert_mtl_pkg::PIPE_LAT
) (
  input  logic                          CLK_33,
  input  logic                          reset,
  input  logic                          run,
`ifdef MTL_TEST_PATTERN_EN
  input  logic                          test_mode,
`endif
  mtl_pixel_timing_gen_if.master        pix
);

  localparam logic [10:0] XLast      = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] XActive    = 11'(H_ACTIVE);
  localparam logic [10:0] XSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] XSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  YLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  YActive    = 10'(V_ACTIVE);
  localparam logic [9:0]  YSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  YSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        run_q;
  logic        acked_q, acked_d;
  logic        upd_ack_q, upd_ack_d;
  logic        hs_act, vs_act, de_raw;
  logic        hs_dly, vs_dly, de_dly;
  logic        vblank_next;
  logic        lcd_hsd_q, lcd_vsd_q, lcd_de_q;
  qbert_mtl_pkg::rgb_t rend_rgb, src_rgb, lcd_rgb_q;

  // The first clock after run rises shows (0,0); the counters only advance once that is seen.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!run) begin
      x_d = '0;
      y_d = '0;
    end else if (run_q) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // Syncs travel active-high through the delay line so an async clear means idle.
  assign hs_act = run_q && (x_q >= XSyncStart) && (x_q < XSyncEnd);
  assign vs_act = run_q && (y_q >= YSyncStart) && (y_q < YSyncEnd);
  assign de_raw = run_q && (x_q < XActive) && (y_q < YActive);

  // Look one clock ahead so the grant lands on the first vblank clock itself.
  always_comb begin
    vblank_next = (y_d >= YActive);
    upd_ack_d   = pix.upd_req && !acked_q && vblank_next;
    acked_d     = vblank_next && (acked_q || upd_ack_d);
  end

  mtl_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_LAT)
  ) u_sync_dly (
    .CLK_33 (CLK_33),
    .reset  (reset),
    .d      ({hs_act, vs_act, de_raw}),
    .q      ({hs_dly, vs_dly, de_dly})
  );

  assign rend_rgb = '{r: pix.red_in, g: pix.green_in, b: pix.blue_in};

`ifdef MTL_TEST_PATTERN_EN
  logic [2:0] bar_idx, bar_idx_dly;

  always_comb begin
    bar_idx = '0;
    if (x_q < XActive) bar_idx = 3'(x_q / 11'(qbert_mtl_pkg::BAR_WIDTH));
  end

  mtl_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_LAT)
  ) u_bar_dly (
    .CLK_33 (CLK_33),
    .reset  (reset),
    .d      (bar_idx),
    .q      (bar_idx_dly)
  );

  assign src_rgb = test_mode ? qbert_mtl_pkg::rgb_t'(qbert_mtl_pkg::BAR_TABLE[bar_idx_dly])
                             : rend_rgb;
`else
  assign src_rgb = rend_rgb;
`endif

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      run_q     <= 1'b0;
      acked_q   <= 1'b0;
      upd_ack_q <= 1'b0;
      lcd_rgb_q <= '0;
      lcd_hsd_q <= 1'b1;
      lcd_vsd_q <= 1'b1;
      lcd_de_q  <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      run_q     <= run;
      acked_q   <= acked_d;
      upd_ack_q <= upd_ack_d;
      lcd_rgb_q <= de_dly ? src_rgb : '0;
      lcd_hsd_q <= ~hs_dly;
      lcd_vsd_q <= ~vs_dly;
      lcd_de_q  <= de_dly;
    end
  end

  assign pix.x_cnt       = x_q;
  assign pix.y_cnt       = y_q;
  assign pix.lcd_r       = lcd_rgb_q.r;
  assign pix.lcd_g       = lcd_rgb_q.g;
  assign pix.lcd_b       = lcd_rgb_q.b;
  assign pix.lcd_hsd     = lcd_hsd_q;
  assign pix.lcd_vsd     = lcd_vsd_q;
  assign pix.lcd_de      = lcd_de_q;
  assign pix.frame_start = run_q && (x_q == '0) && (y_q == '0);
  assign pix.vblank      = run_q && (y_q >= YActive);
  assign pix.upd_ack     = upd_ack_q;

endmodule
